// File: rtl/data_bus_rr_arbiter.sv
// Two-master round-robin arbiter sharing one fixed-latency slave data port.
// Optional master lock is compiled in by defining DATA_BUS_ARB_LOCK_EN.
module data_bus_rr_arbiter #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      m0_req_i,
    output logic                      m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
    input  logic                      m0_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
    input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
    output logic                      m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m0_rdata_o,

    input  logic                      m1_req_i,
    output logic                      m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
    input  logic                      m1_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
    input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
    output logic                      m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m1_rdata_o,

`ifdef DATA_BUS_ARB_LOCK_EN
    input  logic                      m0_lock_i,
    input  logic                      m1_lock_i,
`endif

    output logic                      s_req_o,
    input  logic                      s_gnt_i,
    output logic [ADDR_WIDTH-1:0]     s_addr_o,
    output logic                      s_we_o,
    output logic [DATA_WIDTH/8-1:0]   s_be_o,
    output logic [DATA_WIDTH-1:0]     s_wdata_o,
    input  logic [DATA_WIDTH-1:0]     s_rdata_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("data_bus_rr_arbiter: LATENCY must be in 1..4");
    end

    logic                prio_q;
    logic                sel_vld;
    logic                sel_id;
    logic                accept;
    logic                lock_hold;
    logic [LATENCY-1:0]  pipe_vld_q;
    logic [LATENCY-1:0]  pipe_id_q;

`ifdef DATA_BUS_ARB_LOCK_EN
    // Last accepted master; a lock only ever holds the bus for this master.
    logic last_vld_q;
    logic last_id_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_vld_q <= 1'b0;
            last_id_q  <= 1'b0;
        end else if (accept) begin
            last_vld_q <= 1'b1;
            last_id_q  <= sel_id;
        end
    end

    always_comb begin
        lock_hold = 1'b0;
        if (last_vld_q) begin
            if (last_id_q) begin
                lock_hold = m1_req_i && m1_lock_i;
            end else begin
                lock_hold = m0_req_i && m0_lock_i;
            end
        end
    end
`else
    assign lock_hold = 1'b0;
`endif

    // Request selection: lock owner first, then round-robin on contention.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = 1'b0;
        if (lock_hold) begin
            sel_vld = 1'b1;
`ifdef DATA_BUS_ARB_LOCK_EN
            sel_id  = last_id_q;
`endif
        end else if (m0_req_i && m1_req_i) begin
            sel_vld = 1'b1;
            sel_id  = prio_q;
        end else if (m0_req_i) begin
            sel_vld = 1'b1;
            sel_id  = 1'b0;
        end else if (m1_req_i) begin
            sel_vld = 1'b1;
            sel_id  = 1'b1;
        end
    end

    assign accept   = sel_vld && s_gnt_i;
    assign m0_gnt_o = accept && !sel_id;
    assign m1_gnt_o = accept && sel_id;
    assign s_req_o  = sel_vld;

    // Slave request fields follow the selected master, zero when idle.
    always_comb begin
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (sel_vld) begin
            if (sel_id) begin
                s_addr_o  = m1_addr_i;
                s_we_o    = m1_we_i;
                s_be_o    = BE_WIDTH'(m1_be_i);
                s_wdata_o = m1_wdata_i;
            end else begin
                s_addr_o  = m0_addr_i;
                s_we_o    = m0_we_i;
                s_be_o    = BE_WIDTH'(m0_be_i);
                s_wdata_o = m0_wdata_i;
            end
        end
    end

    // Priority flips away from the master just served; stalls never rotate it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= ~sel_id;
        end
    end

    // Owner pipeline: one {valid,id} slot per cycle of slave latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
        end else begin
            pipe_vld_q <= LATENCY'({pipe_vld_q, accept});
            pipe_id_q  <= LATENCY'({pipe_id_q, sel_id});
        end
    end

    assign m0_rvalid_o = pipe_vld_q[LATENCY-1] && !pipe_id_q[LATENCY-1];
    assign m1_rvalid_o = pipe_vld_q[LATENCY-1] && pipe_id_q[LATENCY-1];
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

endmodule
